pwm_phased: RTL and testbench

PWM_PHASED -- requirements
Module: pwm_phased

---
 rtl/pwm_phased.sv | 110 +++++++++++
 tb/tb_pwm_phased.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_phased.sv
// Multi-channel phase-shifted PWM with a shared period counter and double-buffered duty/phase.
// Define PWM_PHASED_COMPL_EN to add the complementary output bus pwm_n.
module pwm_phased #(
    parameter int CHANNELS = 8,
    parameter int PERIOD   = 1250,
    parameter int CW       = 11,
    parameter int AW       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_ch,
    input  logic [CW-1:0]       wr_duty,
    input  logic [CW-1:0]       wr_phase,
    output logic [CHANNELS-1:0] pwm,
`ifdef PWM_PHASED_COMPL_EN
    output logic [CHANNELS-1:0] pwm_n,
`endif
    output logic                period_start
);

    localparam logic [CW-1:0] PERIOD_C  = CW'(PERIOD);
    localparam logic [CW:0]   PERIOD_P1 = (CW+1)'(PERIOD + 1);

    typedef struct packed {
        logic [CW-1:0] duty;
        logic [CW-1:0] phase;
    } chan_cfg_t;

    logic [CW-1:0]       ctr_q, ctr_d;
    logic                wrap, commit;
    chan_cfg_t           shadow_q [CHANNELS];
    chan_cfg_t           active_q [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                period_start_q, period_start_d;

    // Count position relative to the channel's delayed period start, kept at
    // CW+1 bits so ctr+PERIOD+1 cannot overflow.
    function automatic logic [CW:0] shifted_count(input logic [CW-1:0] c,
                                                  input logic [CW-1:0] ph);
        logic [CW-1:0] p;
        logic [CW:0]   ce;
        logic [CW:0]   pe;
        p  = (ph > PERIOD_C) ? PERIOD_C : ph;
        ce = {1'b0, c};
        pe = {1'b0, p};
        if (c >= p) return ce - pe;
        else        return ce + PERIOD_P1 - pe;
    endfunction

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        wrap           = en && (ctr_q == PERIOD_C);
        commit         = wrap || !en;
        ctr_d          = '0;
        if (en && !wrap) ctr_d = ctr_q + CW'(1);
        period_start_d = en && (ctr_q == '0);
        pwm_d          = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = en && ({1'b0, active_q[i].duty} > shifted_count(ctr_q, active_q[i].phase));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_q          <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            ctr_q          <= ctr_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    // NOTE: the configuration arrays are small flop banks, not RAM, so they are cleared by reset like any register.
    // NOTE: non-blocking updates mean a commit on the same edge as a write copies the pre-write shadow value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (commit) active_q[i] <= shadow_q[i];
                // Matching against each real channel index drops out-of-range addresses.
                if (wr_en && (wr_ch == AW'(i))) begin
                    shadow_q[i] <= '{duty: wr_duty, phase: wr_phase};
                end
            end
        end
    end

    assign pwm          = pwm_q;
    assign period_start = period_start_q;

`ifdef PWM_PHASED_COMPL_EN
    logic [CHANNELS-1:0] pwm_n_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pwm_n_q <= '0;
        else      pwm_n_q <= en ? ~pwm_d : '0;
    end

    assign pwm_n = pwm_n_q;
`endif

endmodule

// File: tb/tb_pwm_phased.sv
// Directed bench for pwm_phased: per-channel duty/phase table measured over one period,
// followed by hand sequences for shadow timing, enable drop, async reset and bad addresses.
module tb_pwm_phased;

    localparam int CH  = 8;
    localparam int PER = 1250;
    localparam int CW  = 11;
    localparam int AW  = 4;
    localparam int N   = PER + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          wr_en;
    logic [AW-1:0] wr_ch;
    logic [CW-1:0] wr_duty;
    logic [CW-1:0] wr_phase;
    logic [CH-1:0] pwm;
    logic          period_start;
`ifdef PWM_PHASED_COMPL_EN
    logic [CH-1:0] pwm_n;
`endif

    pwm_phased #(.CHANNELS(CH), .PERIOD(PER), .CW(CW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .wr_phase     (wr_phase),
        .pwm          (pwm),
`ifdef PWM_PHASED_COMPL_EN
        .pwm_n        (pwm_n),
`endif
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    typedef struct {
        int hi;
        int ps_cnt;
        int ps_first;
        int first_hi;
        int first_lo;
        int any_hi;
    } win_t;

    typedef struct {
        int ch;
        int duty;
        int phase;
        int exp_hi;
        int exp_first_hi;
        int exp_first_lo;
    } vec_t;

    // Sample n consecutive negedges; sample j of a period reflects ctr=j.
    // Optionally drive a write to channel ch right after sample wr_at.
    task automatic run_window(input int ch, input int n, input int wr_at,
                              input int wdata, output win_t w);
        w.hi = 0; w.ps_cnt = 0; w.ps_first = -1;
        w.first_hi = -1; w.first_lo = -1; w.any_hi = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (pwm[ch]) begin
                w.hi++;
                if (w.first_hi < 0) w.first_hi = j;
            end else if (w.first_lo < 0) begin
                w.first_lo = j;
            end
            if (pwm != '0) w.any_hi++;
            if (period_start) begin
                w.ps_cnt++;
                if (w.ps_first < 0) w.ps_first = j;
            end
            if (j == wr_at) begin
                wr_en    = 1'b1;
                wr_ch    = AW'(ch);
                wr_duty  = CW'(wdata);
                wr_phase = '0;
            end
        end
    endtask

    // Stop, write one channel, and let one more idle edge commit it.
    task automatic set_cfg(input int ch, input int duty, input int phase);
        @(negedge clk);
        en       = 1'b0;
        wr_en    = 1'b1;
        wr_ch    = AW'(ch);
        wr_duty  = CW'(duty);
        wr_phase = CW'(phase);
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        vec_t vecs[10];
        win_t w;
        int   g4, g5, g6, ps3;

        vecs[0] = '{0,  625,    0,  625, 0,  625};
        vecs[1] = '{3,  100, 1200,  100, 0,   49};
        vecs[2] = '{1,    1,    0,    1, 0,    1};
        vecs[3] = '{2, 1250,    0, 1250, 0, 1250};
        vecs[4] = '{4, 1251, 2000, 1251, 0,   -1};
        vecs[5] = '{5,    0, 2000,    0, -1,   0};
        vecs[6] = '{6, 2047, 2000, 1251, 0,   -1};
        vecs[7] = '{7,   10,    5,   10, 5,    0};
        vecs[8] = '{7,  300, 1250,  300, 0,  299};
        vecs[9] = '{0, 1250,    1, 1250, 1,    0};

        rst = 1'b0; en = 1'b0; wr_en = 1'b0;
        wr_ch = '0; wr_duty = '0; wr_phase = '0;
        #12;
        check("reset_pwm", pwm, 0);
        check("reset_ps", period_start, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 10; v++) begin
            set_cfg(vecs[v].ch, vecs[v].duty, vecs[v].phase);
            check($sformatf("v%0d_idle_pwm", v), pwm, 0);
            en = 1'b1;
            run_window(vecs[v].ch, N, -1, 0, w);
            check($sformatf("v%0d_hi", v), w.hi, vecs[v].exp_hi);
            check($sformatf("v%0d_first_hi", v), w.first_hi, vecs[v].exp_first_hi);
            check($sformatf("v%0d_first_lo", v), w.first_lo, vecs[v].exp_first_lo);
            check($sformatf("v%0d_ps_cnt", v), w.ps_cnt, 1);
            check($sformatf("v%0d_ps_first", v), w.ps_first, 0);
            @(negedge clk);
            check($sformatf("v%0d_ps_next", v), period_start, 1);
        end

        // Constant outputs across three full periods, including both wraps.
        set_cfg(4, 1251, 2000);
        en = 1'b1;
        g4 = 0; g5 = 0; g6 = 0; ps3 = 0;
        for (int j = 0; j < 3 * N; j++) begin
            @(negedge clk);
            if (pwm[4] !== 1'b1) g4++;
            if (pwm[5] !== 1'b0) g5++;
            if (pwm[6] !== 1'b1) g6++;
            if (period_start) ps3++;
        end
        check("glitch_ch4", g4, 0);
        check("glitch_ch5", g5, 0);
        check("glitch_ch6", g6, 0);
        check("glitch_ps", ps3, 3);

        // Shadow write mid-period, then a write landing on the wrap edge.
        set_cfg(1, 625, 0);
        en = 1'b1;
        run_window(1, N, 100, 200, w);
        check("mid_cur_hi", w.hi, 625);
        check("mid_cur_ps", w.ps_first, 0);
        run_window(1, N, -1, 0, w);
        check("mid_next_hi", w.hi, 200);
        check("mid_next_ps", w.ps_first, 0);
        run_window(1, N, N - 2, 625, w);
        check("wrapwr_cur_hi", w.hi, 200);
        run_window(1, N, -1, 0, w);
        check("wrapwr_pre_hi", w.hi, 200);
        run_window(1, N, -1, 0, w);
        check("wrapwr_new_hi", w.hi, 625);
        check("wrapwr_ps", w.ps_first, 0);

        // Enable dropped while ctr=700, then restored.
        set_cfg(0, 1251, 0);
        en = 1'b1;
        run_window(0, 699, -1, 0, w);
        @(negedge clk);
        check("endrop_before", pwm[0], 1);
        en = 1'b0;
        @(negedge clk);
        check("endrop_pwm", pwm, 0);
        check("endrop_ps", period_start, 0);
        run_window(0, 20, -1, 0, w);
        check("endrop_idle_pwm", w.any_hi, 0);
        check("endrop_idle_ps", w.ps_cnt, 0);
        en = 1'b1;
        @(negedge clk);
        check("reen_ps", period_start, 1);
        check("reen_pwm", pwm[0], 1);
        run_window(0, N - 1, -1, 0, w);
        check("reen_hi", w.hi, N - 1);
        check("reen_ps_cnt", w.ps_cnt, 0);
        @(negedge clk);
        check("reen_ps_next", period_start, 1);

        // Asynchronous reset between edges clears outputs and all configuration.
        set_cfg(0, 625, 0);
        en = 1'b1;
        run_window(0, 100, -1, 0, w);
        check("arst_before", pwm[0], 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_pwm", pwm, 0);
        check("arst_ps", period_start, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("arst_restart_ps", period_start, 1);
        check("arst_restart_pwm", pwm, 0);
        run_window(0, N - 1, -1, 0, w);
        check("arst_cleared", w.any_hi, 0);
        check("arst_ps_cnt", w.ps_cnt, 0);

        // Writes to channels beyond CHANNELS-1 must not land anywhere.
        set_cfg(9, 1251, 0);
        set_cfg(8, 1251, 0);
        en = 1'b1;
        run_window(0, N, -1, 0, w);
        check("badch_pwm", w.any_hi, 0);
        check("badch_ps", w.ps_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
